timing_sequencer: RTL and testbench

- Controller that sequences the modulo-8 count/decode datapath as a timing-signal generator.
- Produces a programmable-length sequence of one-hot timing states T0..T(last) with run, pause, single-step and abort control.
- Sits between front-panel style controls (start/stop/step buttons) and downstream logic that consumes the one-hot timing_out strobes.

---
 rtl/exp8_pkg.sv | 13 +
 rtl/decoder_3to8.sv | 14 +
 rtl/rise_edge_detect.sv | 19 +
 rtl/timing_sequencer.sv | 109 ++++++++++
 tb/tb_timing_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/exp8_pkg.sv
// Shared definitions for the modulo-8 timing sequencer: state encoding and default count width.
package exp8_pkg;

  localparam int WIDTH_DEF = 3;

  // The encoding 2'd3 is never produced; the sequencer decodes it as idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_3to8.sv
// Binary-to-one-hot decoder; purely combinational, zero latency.
module decoder_3to8 #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]      sel,
  output logic [2**WIDTH-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: pulse is high for the cycle where d is high and its registered copy is low.
// Pulse is combinational from d and the register; there is no backpressure.
module rise_edge_detect (
  input  logic clockpulse,
  input  logic clear_,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) d_q <= 1'b0;
    else         d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/timing_sequencer.sv
// Run/pause/step/abort sequencer producing one-hot timing strobes T0..T(last).
// All outputs registered or decoded from registers; one-cycle response to controls, no backpressure.
module timing_sequencer
  import exp8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clockpulse,
  input  logic                  clear_,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      last_state,
  output logic [WIDTH-1:0]      counter_out,
  output logic [2**WIDTH-1:0]   decoder_out,
  output logic                  busy,
  output logic                  done
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               step_pulse;
  logic               advance;
  logic [2**WIDTH-1:0] onehot;

  rise_edge_detect u_step_edge (
    .clockpulse (clockpulse),
    .clear_     (clear_),
    .d          (step),
    .pulse      (step_pulse)
  );

  decoder_3to8 #(.WIDTH(WIDTH)) u_decode (
    .sel    (count_q),
    .onehot (onehot)
  );

  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (stop) state_d = ST_PAUSE;
        else      advance = 1'b1;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
          last_d  = last_state;
          mode_d  = mode;
        end
      end
    endcase

    // Shared by RUN and single-step: increment, wrap, or finish the pass.
    if (advance) begin
      if (count_q < last_q) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = '0;
        done_d  = 1'b1;
        if (!mode_q) state_d = ST_IDLE;
      end
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign counter_out = count_q;
  assign decoder_out = busy ? onehot : '0;
  assign done        = done_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer: vector table, directed corner sequences and random run vs. a reference model.
module tb_timing_sequencer;

  logic       clockpulse = 1'b0;
  logic       clear_;
  logic       start, stop, step, mode;
  logic [2:0] last_state;
  logic [2:0] counter_out;
  logic [7:0] decoder_out;
  logic       busy, done;

  timing_sequencer #(.WIDTH(3)) dut (
    .clockpulse  (clockpulse),
    .clear_      (clear_),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .mode        (mode),
    .last_state  (last_state),
    .counter_out (counter_out),
    .decoder_out (decoder_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clockpulse = ~clockpulse;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase 0 = idle, 1 = running, 2 = paused.
  int m_phase, m_cnt, m_last, m_done;
  bit m_mode, m_step_prev;

  typedef struct {
    bit         start, stop, step, mode;
    logic [2:0] last;
    logic [2:0] cnt;
    logic [7:0] dec;
    bit         busy, done;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] dut_pack();
    return {counter_out, decoder_out, busy, done};
  endfunction

  function automatic logic [12:0] model_pack();
    logic [2:0] c;
    logic [7:0] d;
    c = m_cnt[2:0];
    d = (m_phase != 0) ? (8'd1 << m_cnt) : 8'd0;
    return {c, d, (m_phase != 0), (m_done != 0)};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: cnt/dec/busy/done got %0d/%h/%b/%b expected %0d/%h/%b/%b",
               name, $time, act[12:10], act[9:2], act[1], act[0],
               exp[12:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_last = 0; m_mode = 0; m_done = 0; m_step_prev = 0;
  endtask

  task automatic model_advance();
    if (m_cnt < m_last) m_cnt = m_cnt + 1;
    else begin
      m_cnt  = 0;
      m_done = 1;
      if (!m_mode) m_phase = 0;
    end
  endtask

  task automatic model_edge();
    bit rise;
    rise = step && !m_step_prev;
    m_step_prev = step;
    m_done = 0;
    case (m_phase)
      0: if (start) begin
           m_phase = 1; m_cnt = 0; m_last = int'(last_state); m_mode = mode;
         end
      1: if (stop) m_phase = 2;
         else model_advance();
      default: if (stop) begin
                 m_phase = 0; m_cnt = 0;
               end else if (start) m_phase = 1;
               else if (rise) model_advance();
    endcase
  endtask

  task automatic tick(input string name);
    @(posedge clockpulse);
    model_edge();
    #1;
    check(name, dut_pack(), model_pack());
  endtask

  task automatic drive(input bit st, input bit sp, input bit stp, input bit md, input logic [2:0] ls);
    start = st; stop = sp; step = stp; mode = md; last_state = ls;
  endtask

  task automatic add(input bit st, input bit sp, input bit stp, input bit md, input logic [2:0] ls,
                     input logic [2:0] c, input logic [7:0] d, input bit b, input bit dn);
    vec_t v;
    v.start = st; v.stop = sp; v.step = stp; v.mode = md; v.last = ls;
    v.cnt = c; v.dec = d; v.busy = b; v.done = dn;
    tbl.push_back(v);
  endtask

  initial begin
    int dones;
    clear_ = 1'b0;
    drive(0, 0, 0, 0, 3'd0);
    model_reset();
    #12 clear_ = 1'b1;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick("idle_model");
      check("idle_zero", dut_pack(), 13'd0);
    end

    // Single pass last=3, step in idle ignored
    add(0,0,1,0,3'd3, 3'd0, 8'h00, 0, 0);
    add(1,0,0,0,3'd3, 3'd0, 8'h01, 1, 0);
    add(0,0,0,1,3'd6, 3'd1, 8'h02, 1, 0);
    add(0,0,0,1,3'd6, 3'd2, 8'h04, 1, 0);
    add(0,0,0,0,3'd0, 3'd3, 8'h08, 1, 0);
    add(0,0,0,0,3'd0, 3'd0, 8'h00, 0, 1);
    add(0,0,0,0,3'd0, 3'd0, 8'h00, 0, 0);
    // Pause, held step, second step, resume
    add(1,0,0,0,3'd7, 3'd0, 8'h01, 1, 0);
    add(0,0,0,0,3'd7, 3'd1, 8'h02, 1, 0);
    add(0,0,0,0,3'd7, 3'd2, 8'h04, 1, 0);
    add(0,1,0,0,3'd7, 3'd2, 8'h04, 1, 0);
    for (int i = 0; i < 5; i++) add(0,0,1,0,3'd7, 3'd3, 8'h08, 1, 0);
    add(0,0,0,0,3'd7, 3'd3, 8'h08, 1, 0);
    add(0,0,1,0,3'd7, 3'd4, 8'h10, 1, 0);
    add(1,0,0,0,3'd7, 3'd4, 8'h10, 1, 0);
    add(0,0,0,0,3'd7, 3'd5, 8'h20, 1, 0);
    add(0,0,0,0,3'd7, 3'd6, 8'h40, 1, 0);
    // Pause then stop+start together aborts
    add(0,1,0,0,3'd7, 3'd6, 8'h40, 1, 0);
    add(1,1,0,0,3'd7, 3'd0, 8'h00, 0, 0);
    add(0,0,0,0,3'd7, 3'd0, 8'h00, 0, 0);
    // Stop at count==last in continuous mode: pause at last, no done
    add(1,0,0,1,3'd2, 3'd0, 8'h01, 1, 0);
    add(0,0,0,1,3'd2, 3'd1, 8'h02, 1, 0);
    add(0,0,0,1,3'd2, 3'd2, 8'h04, 1, 0);
    add(0,1,0,1,3'd2, 3'd2, 8'h04, 1, 0);
    add(0,0,0,1,3'd2, 3'd2, 8'h04, 1, 0);
    add(0,0,1,1,3'd2, 3'd0, 8'h01, 1, 1);
    add(0,1,0,1,3'd2, 3'd0, 8'h00, 0, 0);
    // last_state=0 continuous: T0 with done every cycle
    add(1,0,0,1,3'd0, 3'd0, 8'h01, 1, 0);
    add(0,0,0,0,3'd5, 3'd0, 8'h01, 1, 1);
    add(0,0,0,0,3'd5, 3'd0, 8'h01, 1, 1);
    add(0,1,0,0,3'd5, 3'd0, 8'h01, 1, 0);
    add(0,1,0,0,3'd5, 3'd0, 8'h00, 0, 0);
    // last_state=0 single pass: one cycle of T0, then idle with done
    add(1,0,0,0,3'd0, 3'd0, 8'h01, 1, 0);
    add(0,0,0,0,3'd0, 3'd0, 8'h00, 0, 1);
    add(0,0,0,0,3'd0, 3'd0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].step, tbl[i].mode, tbl[i].last);
      tick("tbl_model");
      check($sformatf("tbl[%0d]", i), dut_pack(),
            {tbl[i].cnt, tbl[i].dec, tbl[i].busy, tbl[i].done});
    end

    // Continuous last=7 for 20 cycles, done at the two wraps
    drive(1, 0, 0, 1, 3'd7);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick("cont_model");
      start = 1'b0;
      check("cont_cnt", {counter_out, 10'd0}, {3'(i % 8), 10'd0});
      if (done) dones++;
    end
    check("cont_dones", {10'd0, 3'(dones)}, {10'd0, 3'd2});
    drive(0, 1, 0, 0, 3'd0);
    tick("cont_pause");
    tick("cont_abort");

    // Async reset mid-run at count 5; last_state change mid-run is ignored
    drive(1, 0, 0, 1, 3'd7);
    tick("ar_start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick("ar_run");
    last_state = 3'd2;
    tick("ar_run5");
    check("ar_cnt5", dut_pack(), {3'd5, 8'h20, 1'b1, 1'b0});
    #3 clear_ = 1'b0;
    #1;
    check("ar_async_zero", dut_pack(), 13'd0);
    model_reset();
    #2 clear_ = 1'b1;
    drive(0, 0, 0, 0, 3'd0);
    tick("ar_idle");
    check("ar_idle_zero", dut_pack(), 13'd0);

    // Random control traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 6) == 0, ($urandom % 9) == 0, ($urandom % 3) == 0,
            $urandom % 2, 3'($urandom % 8));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
